// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line, mid-bit sampling, optional parity,
// 1 or 2 stop bits, framing and line-break detection with a single-cycle completion pulse.
module uart_rx_cfg #(
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sclk,
  input  logic                 s_rst,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned     CntW     = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(CLK_DIV - 1);
  localparam logic [3:0]      BitLast  = 4'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParEn    = (PARITY_EN != 0);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

`ifndef SYNTHESIS
  if (CLK_DIV < 8) begin : g_bad_clk_div
    $error("uart_rx_cfg: CLK_DIV must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY_EN and PARITY_ODD must be 0 or 1");
  end
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  // Synchroniser plus one extra stage for falling-edge detection; all idle high.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rs232_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 stop_low_q;
  logic                 stop0_low_q;

  logic fall_edge, tick, stop_bad, first_stop_low, is_break, par_bad;

  always_comb begin
    fall_edge      = ~rx_sync_q & rx_prev_q;
    tick           = (state_q == StStart) ? (cnt_q == CntHalf) : (cnt_q == CntFull);
    // Values below are only consumed at the final stop sample, so they fold in the live sample.
    stop_bad       = stop_low_q | ~rx_sync_q;
    first_stop_low = (stop_cnt_q == 1'b0) ? ~rx_sync_q : stop0_low_q;
    is_break       = (shift_q == '0) && !(ParEn && par_bit_q) && first_stop_low;
    par_bad        = ParEn && ((^shift_q ^ par_bit_q) != ParOdd);
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      stop_low_q  <= 1'b0;
      stop0_low_q <= 1'b0;
      rx_data     <= '0;
      po_flag     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      po_flag <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fall_edge) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_sync_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BitLast) begin
              bit_cnt_q   <= '0;
              stop_cnt_q  <= 1'b0;
              stop_low_q  <= 1'b0;
              stop0_low_q <= 1'b0;
              par_bit_q   <= 1'b0;
              state_q     <= ParEn ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (tick) begin
            cnt_q     <= '0;
            par_bit_q <= rx_sync_q;
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (tick) begin
            cnt_q <= '0;
            if (stop_cnt_q == StopLast) begin
              // Leave mid-stop-bit so a back-to-back start edge is not missed.
              po_flag    <= 1'b1;
              rx_data    <= shift_q;
              parity_err <= par_bad;
              frame_err  <= stop_bad;
              break_det  <= is_break;
              state_q    <= is_break ? StBrkWait : StIdle;
            end else begin
              stop_cnt_q  <= 1'b1;
              stop_low_q  <= ~rx_sync_q;
              stop0_low_q <= ~rx_sync_q;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBrkWait: begin
          if (rx_sync_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) at CLK_DIV=16, each with its own line,
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int unsigned Div = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line = 3'b111;

  logic [7:0] data_a, data_p;
  logic [6:0] data_c;
  logic       flag_a, flag_p, flag_c;
  logic       pe_a, pe_p, pe_c, fe_a, fe_p, fe_c, bd_a, bd_p, bd_c;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.sclk(clk), .s_rst(rst), .rs232_rx(rx_line[0]), .rx_data(data_a), .po_flag(flag_a),
           .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a));
  uart_rx_cfg #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.sclk(clk), .s_rst(rst), .rs232_rx(rx_line[1]), .rx_data(data_p), .po_flag(flag_p),
           .parity_err(pe_p), .frame_err(fe_p), .break_det(bd_p));
  uart_rx_cfg #(.CLK_DIV(Div), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_7n2 (.sclk(clk), .s_rst(rst), .rs232_rx(rx_line[2]), .rx_data(data_c), .po_flag(flag_c),
           .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c));

  obs_t       cur [3];
  logic [2:0] flag;
  assign cur[0] = {1'b0, data_a, pe_a, fe_a, bd_a};
  assign cur[1] = {1'b0, data_p, pe_p, fe_p, bd_p};
  assign cur[2] = {2'b00, data_c, pe_c, fe_c, bd_c};
  assign flag   = {flag_c, flag_p, flag_a};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t        cap     [3][$];
  int unsigned cap_cyc [3][$];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (flag[k]) begin
        cap[k].push_back(cur[k]);
        cap_cyc[k].push_back(cyc);
      end
    end
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t last_exp [3];

  function automatic int nbits_of(int ch);
    return (ch == 2) ? 7 : 8;
  endfunction

  function automatic int nstop_of(int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  // Frame-level expectation from the data word, parity bit and stop bits placed on the line.
  function automatic obs_t model(int ch, logic [8:0] data, logic pbit, logic [1:0] stops);
    obs_t m;
    int   ones = 0;
    logic pen  = (ch == 1);
    m = '0;
    for (int i = 0; i < nbits_of(ch); i++) begin
      if (data[i]) begin
        ones++;
        m.data[i] = 1'b1;
      end
    end
    m.pe = pen && (((ones + int'(pbit)) % 2) != 0);
    m.fe = !stops[0] || (nstop_of(ch) == 2 && !stops[1]);
    m.bd = (m.data == 9'd0) && (!pen || !pbit) && !stops[0];
    return m;
  endfunction

  task automatic hold_bit(input int ch, input logic b, input int unsigned n);
    rx_line[ch] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, output int unsigned t0);
    t0 = cyc;
    hold_bit(ch, 1'b0, Div);
    for (int i = 0; i < nbits_of(ch); i++) hold_bit(ch, data[i], Div);
    if (ch == 1) hold_bit(ch, pbit, Div);
    for (int i = 0; i < nstop_of(ch); i++) hold_bit(ch, stops[i], Div);
  endtask

  task automatic take(input int ch, output obs_t o, output int unsigned c);
    if (cap[ch].size() > 0) begin
      o = cap[ch].pop_front();
      c = cap_cyc[ch].pop_front();
    end else begin
      o = '1;
      c = 0;
    end
  endtask

  task automatic flush_caps();
    for (int k = 0; k < 3; k++) begin
      cap[k].delete();
      cap_cyc[k].delete();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({cur[k], flag[k]} !== 13'd0) $display("FAIL reset_outputs ch%0d: got %h want 0", k, {cur[k], flag[k]});
      else n_pass++;
      last_exp[k] = '0;
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int unsigned t0, t1, c, lat, lmin;
    flush_caps();
    send_frame(0, 9'h055, 1'b0, 2'b11, t0);
    send_frame(0, 9'h0A3, 1'b0, 2'b11, t1);
    hold_bit(0, 1'b1, 2 * Div);
    n_checks++;
    if (cap[0].size() !== 2) $display("FAIL b2b_count: got %0d want 2", cap[0].size());
    else n_pass++;
    take(0, o, c);
    e = model(0, 9'h055, 1'b0, 2'b11);
    n_checks++;
    if (o !== e) $display("FAIL b2b_frame0: got %h want %h", o, e);
    else n_pass++;
    lat  = c - t0;
    lmin = Div / 2 + 9 * Div + 1;
    n_checks++;
    if (lat < lmin || lat > lmin + 3) $display("FAIL latency: got %0d want %0d..%0d", lat, lmin, lmin + 3);
    else n_pass++;
    take(0, o, c);
    e = model(0, 9'h0A3, 1'b0, 2'b11);
    n_checks++;
    if (o !== e) $display("FAIL b2b_frame1: got %h want %h", o, e);
    else n_pass++;
    last_exp[0] = e;
  endtask

  task automatic test_parity();
    obs_t o, e;
    int unsigned t0, c;
    flush_caps();
    for (int p = 0; p < 2; p++) begin
      send_frame(1, 9'h007, 1'(p), 2'b11, t0);
      hold_bit(1, 1'b1, 2 * Div);
      take(1, o, c);
      e = model(1, 9'h007, 1'(p), 2'b11);
      n_checks++;
      if (o !== e) $display("FAIL parity_pbit%0d: got %h want %h", p, o, e);
      else n_pass++;
      last_exp[1] = e;
    end
  endtask

  task automatic test_frame_err();
    obs_t o, e;
    int unsigned t0, c;
    flush_caps();
    send_frame(0, 9'h03C, 1'b0, 2'b10, t0);
    hold_bit(0, 1'b1, 2 * Div);
    take(0, o, c);
    e = model(0, 9'h03C, 1'b0, 2'b10);
    n_checks++;
    if (o !== e) $display("FAIL frame_err: got %h want %h", o, e);
    else n_pass++;
    last_exp[0] = e;
  endtask

  task automatic test_glitch();
    flush_caps();
    hold_bit(0, 1'b0, 4);
    hold_bit(0, 1'b1, 3 * Div);
    n_checks++;
    if (cap[0].size() !== 0) $display("FAIL glitch_flag: got %0d pulses want 0", cap[0].size());
    else n_pass++;
    n_checks++;
    if (cur[0] !== last_exp[0]) $display("FAIL glitch_hold: got %h want %h", cur[0], last_exp[0]);
    else n_pass++;
  endtask

  task automatic test_break();
    obs_t o, e;
    int unsigned t0, c;
    flush_caps();
    hold_bit(0, 1'b0, 20 * Div);
    hold_bit(0, 1'b1, 2 * Div);
    n_checks++;
    if (cap[0].size() !== 1) $display("FAIL break_count: got %0d want 1", cap[0].size());
    else n_pass++;
    take(0, o, c);
    e = '{data: 9'd0, pe: 1'b0, fe: 1'b1, bd: 1'b1};
    n_checks++;
    if (o !== e) $display("FAIL break_frame: got %h want %h", o, e);
    else n_pass++;
    send_frame(0, 9'h081, 1'b0, 2'b11, t0);
    hold_bit(0, 1'b1, 2 * Div);
    take(0, o, c);
    e = model(0, 9'h081, 1'b0, 2'b11);
    n_checks++;
    if (o !== e) $display("FAIL after_break: got %h want %h", o, e);
    else n_pass++;
    last_exp[0] = e;
  endtask

  task automatic test_random();
    obs_t o, e;
    int unsigned t0, c;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;
    flush_caps();
    for (int ch = 0; ch < 3; ch++) begin
      for (int n = 0; n < 8; n++) begin
        d  = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 5) == 0) d = '0;
        pb = 1'($urandom_range(0, 1));
        st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
        send_frame(ch, d, pb, st, t0);
        hold_bit(ch, 1'b1, 2 * Div);
        take(ch, o, c);
        e = model(ch, d, pb, st);
        n_checks++;
        if (o !== e) $display("FAIL random ch%0d n%0d d=%h p=%b s=%b: got %h want %h", ch, n, d, pb, st, o, e);
        else n_pass++;
        last_exp[ch] = e;
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int unsigned t0, c;
    logic [8:0] d;
    d = 9'h055;
    flush_caps();
    hold_bit(2, 1'b0, Div);
    for (int i = 0; i < 3; i++) hold_bit(2, d[i], Div);
    hold_bit(2, d[3], Div / 2);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cur[k] !== obs_t'(0)) $display("FAIL midrst_outputs ch%0d: got %h want 0", k, cur[k]);
      else n_pass++;
      last_exp[k] = '0;
    end
    repeat (3) @(negedge clk);
    rx_line = 3'b111;
    rst     = 1'b0;
    repeat (2 * Div) @(negedge clk);
    n_checks++;
    if (cap[2].size() !== 0) $display("FAIL midrst_flag: got %0d pulses want 0", cap[2].size());
    else n_pass++;
    send_frame(2, 9'h0F0, 1'b0, 2'b11, t0);
    hold_bit(2, 1'b1, 2 * Div);
    take(2, o, c);
    e = model(2, 9'h0F0, 1'b0, 2'b11);
    n_checks++;
    if (o !== e) $display("FAIL midrst_frame: got %h want %h", o, e);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch();
    test_break();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
